// File: rtl/sgdmac_splitter.sv
// sgdmac_splitter: steers one inbound word stream to the data writer or the descriptor unit per routed command
module sgdmac_splitter #(
  parameter int DATA_SIZE = 32,
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_sel_i,
  input  logic [LEN_W-1:0]     cmd_len_i,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  input  logic [DATA_SIZE-1:0] src_data_i,
  output logic                 data_writer_valid_o,
  input  logic                 data_writer_ready_i,
  output logic [DATA_SIZE-1:0] data_writer_data_o,
  output logic                 descriptor_valid_o,
  input  logic                 descriptor_ready_i,
  output logic [DATA_SIZE-1:0] descriptor_data_o,
  output logic                 done_o
);
  typedef enum logic [1:0] {IDLE, ROUTE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic sel_q, sel_d;
  logic dw_valid_q, dw_valid_d, ds_valid_q, ds_valid_d, done_q, done_d;
  logic [DATA_SIZE-1:0] dw_data_q, dw_data_d, ds_data_q, ds_data_d;
  logic out_valid, out_ready, deliver, cmd_hs, src_hs;
  assign out_valid = sel_q ? ds_valid_q : dw_valid_q;
  assign out_ready = sel_q ? descriptor_ready_i : data_writer_ready_i;
  assign deliver = out_valid && out_ready;
  assign cmd_hs = cmd_valid_i && cmd_ready_o;
  assign src_hs = src_valid_i && src_ready_o;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      sel_q      <= 1'b0;
      dw_valid_q <= 1'b0;
      ds_valid_q <= 1'b0;
      dw_data_q  <= '0;
      ds_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sel_q      <= sel_d;
      dw_valid_q <= dw_valid_d;
      ds_valid_q <= ds_valid_d;
      dw_data_q  <= dw_data_d;
      ds_data_q  <= ds_data_d;
      done_q     <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE  ? (cmd_hs && cmd_len_i != '0 ? ROUTE : IDLE) :
              state_q == ROUTE ? (src_hs && rem_q == LEN_W'(1) ? DRAIN : ROUTE) :
              (deliver ? IDLE : DRAIN);
  end
  always_comb begin
    cmd_ready_o = state_q == IDLE;
    src_ready_o = state_q == ROUTE && rem_q != '0 && (!out_valid || out_ready);
  end
  always_comb begin
    rem_d      = cmd_hs ? cmd_len_i : src_hs ? rem_q - LEN_W'(1) : rem_q;
    sel_d      = cmd_hs ? cmd_sel_i : sel_q;
    dw_valid_d = src_hs && !sel_q ? 1'b1 : (dw_valid_q && data_writer_ready_i ? 1'b0 : dw_valid_q);
    ds_valid_d = src_hs && sel_q ? 1'b1 : (ds_valid_q && descriptor_ready_i ? 1'b0 : ds_valid_q);
    dw_data_d  = src_hs && !sel_q ? src_data_i : dw_data_q;
    ds_data_d  = src_hs && sel_q ? src_data_i : ds_data_q;
    done_d     = (cmd_hs && cmd_len_i == '0) || (state_q == DRAIN && deliver);
  end
  assign data_writer_valid_o = dw_valid_q;
  assign data_writer_data_o  = dw_data_q;
  assign descriptor_valid_o  = ds_valid_q;
  assign descriptor_data_o   = ds_data_q;
  assign done_o              = done_q;
endmodule
